// File: rtl/multi_edge_pkg.sv
// Shared definitions for multi_edge_detect: per-channel event-select codes
// and the debounce counter width helper.
// Debounce is compiled in by defining MULTI_EDGE_DEBOUNCE_EN.
package multi_edge_pkg;

  // Per-channel event select codes (mode[2i+1:2i]).
  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Counter width must be able to hold cycles-1 and is never narrower than 1 bit.
  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/edge_chan.sv
// edge_chan: one channel of multi_edge_detect -- synchroniser, optional
// debounce (MULTI_EDGE_DEBOUNCE_EN), rising/falling pulses, sticky event flag.
// Ports: clk, rst (sync, active-high), signal (async raw in), mode[1:0],
//        clr (level flag clear), level, pos_edge, neg_edge, event_flag.
module edge_chan
  import multi_edge_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       signal,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       level,
  output logic       pos_edge,
  output logic       neg_edge,
  output logic       event_flag
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   level_nxt;
  logic                   pos_nxt;
  logic                   neg_nxt;
  logic                   rise_en;
  logic                   fall_en;

  // Synchroniser chain; the last stage is the only one the logic looks at.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], signal};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef MULTI_EDGE_DEBOUNCE_EN
  localparam int               CNT_W   = cnt_width(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;

  // The counter tracks how many consecutive cycles sync has disagreed with
  // level; any agreeing cycle restarts it, which is what drops short glitches.
  always_comb begin
    level_nxt = level;
    cnt_nxt   = '0;
    if (sync != level) begin
      if (cnt_q == CNT_MAX) begin
        level_nxt = sync;
      end else begin
        cnt_nxt = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_nxt;
    end
  end
`else
  logic [31:0] unused_debounce_cyc;
  assign unused_debounce_cyc = 32'(DEBOUNCE_CYC);
  assign level_nxt = sync;
`endif

  assign rise_en = (mode == MODE_RISE) || (mode == MODE_BOTH);
  assign fall_en = (mode == MODE_FALL) || (mode == MODE_BOTH);

  // Pulses come from the next-state level so they line up with the level change.
  assign pos_nxt = level_nxt & ~level;
  assign neg_nxt = ~level_nxt & level;

  always_ff @(posedge clk) begin
    if (rst) begin
      level      <= 1'b0;
      pos_edge   <= 1'b0;
      neg_edge   <= 1'b0;
      event_flag <= 1'b0;
    end else begin
      level      <= level_nxt;
      pos_edge   <= pos_nxt;
      neg_edge   <= neg_nxt;
      // A new enabled edge beats a simultaneous clear.
      event_flag <= (pos_nxt & rise_en) | (neg_nxt & fall_en) | (event_flag & ~clr);
    end
  end

endmodule

// File: rtl/multi_edge_detect.sv
// multi_edge_detect: CH independent edge-detect channels plus an aggregated irq.
// Ports: clk, rst (sync, active-high), signal[CH], mode[2*CH], clr[CH],
//        level/pos_edge/neg_edge/event_flag[CH], irq. Debounce: MULTI_EDGE_DEBOUNCE_EN.
module multi_edge_detect
  import multi_edge_pkg::*;
#(
  parameter int CH           = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   signal,
  input  logic [2*CH-1:0] mode,
  input  logic [CH-1:0]   clr,
  output logic [CH-1:0]   level,
  output logic [CH-1:0]   pos_edge,
  output logic [CH-1:0]   neg_edge,
  output logic [CH-1:0]   event_flag,
  output logic            irq
);

  for (genvar i = 0; i < CH; i++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .signal     (signal[i]),
      .mode       (mode[2*i +: 2]),
      .clr        (clr[i]),
      .level      (level[i]),
      .pos_edge   (pos_edge[i]),
      .neg_edge   (neg_edge[i]),
      .event_flag (event_flag[i])
    );
  end

  // Flags are registered, so irq is glitch-free combinational OR.
  assign irq = |event_flag;

endmodule

// File: tb/tb_multi_edge_detect.sv
// Testbench for multi_edge_detect: directed scenarios with literal expectations
// plus a randomized run, all checked every cycle against a behavioural model.
module tb_multi_edge_detect;

  localparam int CH   = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
`ifdef MULTI_EDGE_DEBOUNCE_EN
  localparam bit DEB_ON = 1'b1;
  localparam int LAT    = SYNC + DEB - 1;
`else
  localparam bit DEB_ON = 1'b0;
  localparam int LAT    = SYNC;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [CH-1:0]   signal = '0;
  logic [2*CH-1:0] mode = '0;
  logic [CH-1:0]   clr = '0;
  logic [CH-1:0]   level;
  logic [CH-1:0]   pos_edge;
  logic [CH-1:0]   neg_edge;
  logic [CH-1:0]   event_flag;
  logic            irq;

  always #5 clk = ~clk;

  multi_edge_detect #(
    .CH           (CH),
    .SYNC_STAGES  (SYNC),
    .DEBOUNCE_CYC (DEB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .signal     (signal),
    .mode       (mode),
    .clr        (clr),
    .level      (level),
    .pos_edge   (pos_edge),
    .neg_edge   (neg_edge),
    .event_flag (event_flag),
    .irq        (irq)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: sync is the raw input delayed SYNC samples; with
  // debounce, level flips once the last DEB synced samples all disagree with it.
  bit            sq [CH][$];
  bit            win[CH][$];
  logic [CH-1:0] m_level = '0;
  logic [CH-1:0] m_pos   = '0;
  logic [CH-1:0] m_neg   = '0;
  logic [CH-1:0] m_flag  = '0;
  bit            model_ok = 1'b0;

  always @(posedge clk) begin
    bit            seen;
    bit            flip;
    logic [CH-1:0] nl;
    nl = '0;
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        sq[c].delete();
        for (int k = 0; k < SYNC; k++) sq[c].push_back(1'b0);
        win[c].delete();
      end
      m_level  = '0;
      m_pos    = '0;
      m_neg    = '0;
      m_flag   = '0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      for (int c = 0; c < CH; c++) begin
        seen = sq[c].pop_front();
        sq[c].push_back(signal[c]);
        if (DEB_ON) begin
          win[c].push_back(seen);
          if (win[c].size() > DEB) void'(win[c].pop_front());
          flip = (win[c].size() == DEB);
          foreach (win[c][k]) if (win[c][k] == m_level[c]) flip = 1'b0;
          nl[c] = flip ? ~m_level[c] : m_level[c];
        end else begin
          nl[c] = seen;
        end
        m_pos[c]   = nl[c] & ~m_level[c];
        m_neg[c]   = ~nl[c] & m_level[c];
        m_flag[c]  = (m_pos[c] & mode[2*c]) | (m_neg[c] & mode[2*c+1]) | (m_flag[c] & ~clr[c]);
        m_level[c] = nl[c];
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("level", 32'(level), 32'(m_level));
      chk("pos_edge", 32'(pos_edge), 32'(m_pos));
      chk("neg_edge", 32'(neg_edge), 32'(m_neg));
      chk("event_flag", 32'(event_flag), 32'(m_flag));
      chk("irq", 32'(irq), 32'(|m_flag));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int hold[CH];

  initial begin
    // Reset, then outputs must stay 0 for 3 cycles.
    step(3);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_level", 32'(level), 32'h0);
      chk("rst_outs", 32'({pos_edge, neg_edge, event_flag}), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
    end

    // ch0 rise-enabled, ch2 fall-enabled.
    mode = 8'b00_10_00_01;
    signal[0] = 1'b1;
    step(LAT);
    chk("ch0_early_level", 32'(level[0]), 32'h0);
    step(1);
    chk("ch0_level", 32'(level[0]), 32'h1);
    chk("ch0_pos", 32'(pos_edge[0]), 32'h1);
    chk("ch0_flag", 32'(event_flag[0]), 32'h1);
    chk("ch0_irq", 32'(irq), 32'h1);
    chk("model_ch0_level", 32'(m_level[0]), 32'h1);
    chk("model_ch0_flag", 32'(m_flag[0]), 32'h1);
    step(1);
    chk("ch0_pos_width", 32'(pos_edge[0]), 32'h0);
    chk("ch0_level_hold", 32'(level[0]), 32'h1);

    // ch1 two-cycle glitch.
    signal[1] = 1'b1;
    step(2);
    signal[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
`ifdef MULTI_EDGE_DEBOUNCE_EN
      chk("ch1_glitch_level", 32'(level[1]), 32'h0);
      chk("ch1_glitch_pos", 32'(pos_edge[1]), 32'h0);
`endif
    end

    // ch2 fall-only: rise pulses without flag, fall pulses with flag.
    signal[2] = 1'b1;
    step(LAT + 1);
    chk("ch2_pos", 32'(pos_edge[2]), 32'h1);
    chk("ch2_flag_on_rise", 32'(event_flag[2]), 32'h0);
    step(3);
    signal[2] = 1'b0;
    step(LAT + 1);
    chk("ch2_neg", 32'(neg_edge[2]), 32'h1);
    chk("ch2_flag_on_fall", 32'(event_flag[2]), 32'h1);
    chk("model_ch2_flag", 32'(m_flag[2]), 32'h1);
    clr[2] = 1'b1;
    step(1);
    clr[2] = 1'b0;
    chk("ch2_clr", 32'(event_flag[2]), 32'h0);

    // ch0: clear coincident with a new enabled edge -> set wins.
    mode[1:0] = 2'b11;
    signal[0] = 1'b0;
    step(LAT);
    clr[0] = 1'b1;
    step(1);
    chk("ch0_neg", 32'(neg_edge[0]), 32'h1);
    chk("ch0_set_wins", 32'(event_flag[0]), 32'h1);
    step(1);
    chk("ch0_clr_flag", 32'(event_flag[0]), 32'h0);
    chk("irq_drop", 32'(irq), 32'h0);
    clr[0] = 1'b0;

    // ch3 both edges, 1-cycle input pulse.
    mode[7:6] = 2'b11;
    signal[3] = 1'b1;
    step(1);
    signal[3] = 1'b0;
    step(SYNC);
`ifndef MULTI_EDGE_DEBOUNCE_EN
    chk("ch3_pos", 32'(pos_edge[3]), 32'h1);
    step(1);
    chk("ch3_neg", 32'(neg_edge[3]), 32'h1);
    chk("ch3_pos_off", 32'(pos_edge[3]), 32'h0);
    chk("ch3_flag", 32'(event_flag[3]), 32'h1);
`else
    step(DEB + 1);
    chk("ch3_glitch_level", 32'(level[3]), 32'h0);
    chk("ch3_glitch_flag", 32'(event_flag[3]), 32'h0);
`endif

    // Randomized run with occasional mid-stream resets.
    for (int c = 0; c < CH; c++) hold[c] = $urandom_range(1, 8);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          signal[c] = ~signal[c];
          hold[c] = $urandom_range(0, 8);
        end else begin
          hold[c]--;
        end
        clr[c] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 31) == 0) mode = 8'($urandom);
      rst = ($urandom_range(0, 399) == 0);
      step(1);
    end
    rst = 1'b0;
    step(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_edge_detect.md
# multi_edge_detect

Multi-channel, parametrised edge detector: the next generation of the single-channel rising-edge detector. Each channel synchronises an asynchronous input, optionally debounces it, and generates rising and falling edge pulses. A per-channel mode selects which edges raise a sticky event flag, and an aggregated interrupt is driven from those flags. The block sits between raw board inputs (buttons, switches, external strobes) and the control FSMs and interrupt logic.

## Interface
- `CH`, 4: number of independent channels (≥1).
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2).
- `DEBOUNCE_CYC`, 4: consecutive stable cycles required before the debounced level changes (≥1). Used only when debounce is compiled in.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `signal`  in  CH  asynchronous raw inputs.
- `mode`  in  2*CH  per-channel event select; channel i uses `mode[2i+1:2i]`. 00 = off, 01 = rise, 10 = fall, 11 = both.
- `clr`  in  CH  per-channel sticky-flag clear, level-sensitive.
- `level`  out  CH  registered, synchronised (and debounced) level.
- `pos_edge`  out  CH  1-cycle pulse on each 0→1 transition of `level`; independent of `mode`.
- `neg_edge`  out  CH  1-cycle pulse on each 1→0 transition of `level`; independent of `mode`.
- `event_flag`  out  CH  sticky flag, set by an edge enabled in `mode`.
- `irq`  out  1  OR of all `event_flag` bits (combinational from registers).

## Operation
- Reset: the synchroniser chain, `level`, the debounce counters, `pos_edge`, `neg_edge` and `event_flag` all clear to 0, so `irq` is 0.
- Synchroniser: a `SYNC_STAGES`-deep flop chain per channel. The last stage is `sync`.
- Debounce (compiled in):
  - When `sync != level`, the counter increments.
  - When the counter equals `DEBOUNCE_CYC-1` and the mismatch persists, `level <= sync` and the counter goes to 0 on that same edge.
  - Any cycle with `sync == level` resets the counter to 0, so glitches shorter than `DEBOUNCE_CYC` cycles are dropped.
  - Counter width is `$clog2(DEBOUNCE_CYC)` bits, with a minimum of 1.
- Edge pulses:
  - `pos_edge` is set on the same clock edge where `level` updates 0→1.
  - `neg_edge` is set on the same clock edge where `level` updates 1→0.
  - Both are cleared on the following edge unless another transition occurs; a new transition back-to-back is possible only without debounce.
- Event flag:
  - Set when (`pos_edge` next-state and `mode[0]`) or (`neg_edge` next-state and `mode[1]`).
  - Cleared when `clr` is high.
  - Set and clear in the same cycle: set wins.
  - Changing `mode` never clears a flag that is already set.
- If an input is high at reset release, `level` rises after the normal latency and produces a genuine `pos_edge` (and a flag, if rise is enabled).
- `rst` asserted mid-debounce discards the pending count. No partial state survives.

## Timing
- Input stable from before edge N:
  - Debounce on: `level`/pulse visible after edge N+SYNC_STAGES+DEBOUNCE_CYC-1 (N+5 with defaults).
  - Debounce off: visible after edge N+SYNC_STAGES.
- `event_flag` asserts on the same edge as the pulse; `irq` follows in the same cycle.
- Pulse width is exactly 1 cycle.
- Channels are fully independent. Simultaneous edges on several channels each produce their own pulse and flag in the same cycle.

## Configuration
- `MULTI_EDGE_DEBOUNCE_EN` defined: counters are instantiated and the latency is as above.
- Not defined: no counters; `level <= sync` every cycle; `DEBOUNCE_CYC` is ignored.

## Structure
- Package `multi_edge_pkg` holds `MODE_OFF`/`MODE_RISE`/`MODE_FALL`/`MODE_BOTH` (2-bit localparams) and the helper for the counter width.
- One sub-module, `edge_chan`, implements a single channel: synchroniser, debounce, pulses and sticky flag. The top generates `CH` instances and reduces the flags to `irq`.

## Test plan
- Reset with `signal`=4'b0000, defaults, debounce on: all outputs 0 for 3 cycles after `rst` falls.
- ch0 mode=01, `signal[0]` held 0→1 from before edge N: `level[0]`, `pos_edge[0]` and `event_flag[0]` go high after edge N+5; the pulse lasts 1 cycle; `irq`=1.
- ch1 glitch high for 2 cycles (debounce on, DEBOUNCE_CYC=4): `level[1]` and `pos_edge[1]` never assert, and the counter returns to 0.
- ch2 mode=10, rise then fall: `pos_edge[2]` pulses but `event_flag[2]` stays 0; on the fall, `neg_edge[2]` and `event_flag[2]` go high.
- `clr[0]` held high in the same cycle as a new enabled edge on ch0: `event_flag[0]` stays 1. Then `clr` alone clears it to 0 and `irq` drops.
- Debounce compiled out, ch3 mode=11, 1-cycle-wide input pulse: `pos_edge[3]` after edge N+2, then `neg_edge[3]` on the next edge; `event_flag[3]`=1.
